// File: rtl/processador_multiciclo.sv
// rtl/processador_multiciclo.sv - multi-cycle 8-bit-ISA core with req/ack memories; optional PROC_PERF_CNT_EN counters
module processador_multiciclo #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_req,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
`ifdef PROC_PERF_CNT_EN
    output logic              halted,
    output logic [31:0]       instret,
    output logic [31:0]       stall_cycles
`else
    output logic              halted
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_BEQZ = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic              halted_q, halted_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;

    logic [2:0]        op;
    logic [1:0]        rd, rs;
    logic [DATA_W-1:0] imm3_dw;
    logic [PC_W-1:0]   imm3_pc, imm5_pc, pc_plus1;

    assign op       = ir_q[7:5];
    assign rd       = ir_q[4:3];
    assign rs       = ir_q[2:1];
    assign imm3_dw  = {{(DATA_W-3){ir_q[2]}}, ir_q[2:0]};
    assign imm3_pc  = {{(PC_W-3){ir_q[2]}}, ir_q[2:0]};
    assign imm5_pc  = {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};
    assign pc_plus1 = pc_q + PC_ONE;

`ifdef PROC_PERF_CNT_EN
    logic [31:0] instret_q, instret_d, stall_q, stall_d;
    logic        retire;
    assign instret      = instret_q;
    assign stall_cycles = stall_q;
`endif

    // Requests are held in flops; the reset term only masks them during the reset cycle itself
    assign imem_req   = imem_req_q & ~reset;
    assign dmem_req   = dmem_req_q & ~reset;
    assign imem_addr  = pc_q;
    assign dmem_addr  = b_q;
    assign dmem_wdata = a_q;
    assign dmem_we    = (op == OP_SW);
    assign halted     = halted_q;

    // Next-state logic: FSM sequencing, register file writes, ALU and PC update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        regs_d     = regs_q;
        halted_d   = halted_q;
        imem_req_d = imem_req_q;
        dmem_req_d = dmem_req_q;
`ifdef PROC_PERF_CNT_EN
        retire     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = regs_q[rd];
                b_d = regs_q[rs];
                if (op == OP_HALT) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
`ifdef PROC_PERF_CNT_EN
                    retire   = 1'b1;
`endif
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d    = S_MEM;
                    dmem_req_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ADD:  regs_d[rd] = a_q + b_q;
                    OP_SUB:  regs_d[rd] = a_q - b_q;
                    OP_ADDI: regs_d[rd] = a_q + imm3_dw;
                    default: ;
                endcase
                if (op == OP_BEQZ && a_q == '0) pc_d = pc_plus1 + imm3_pc;
                else if (op == OP_JMP)          pc_d = pc_plus1 + imm5_pc;
                else                            pc_d = pc_plus1;
                state_d    = S_FETCH;
                imem_req_d = 1'b1;
`ifdef PROC_PERF_CNT_EN
                retire     = 1'b1;
`endif
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_LW) regs_d[rd] = dmem_rdata;
                    pc_d       = pc_plus1;
                    dmem_req_d = 1'b0;
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
`ifdef PROC_PERF_CNT_EN
                    retire     = 1'b1;
`endif
                end
            end
            default: ;
        endcase
`ifdef PROC_PERF_CNT_EN
        instret_d = instret_q + {31'd0, retire};
        stall_d   = stall_q + {31'd0, (state_q == S_FETCH && !imem_ack) ||
                                      (state_q == S_MEM && !dmem_ack)};
`endif
    end

    // State registers with synchronous reset; no side effect survives a reset edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            regs_q     <= '{default: '0};
            halted_q   <= 1'b0;
            imem_req_q <= 1'b1;
            dmem_req_q <= 1'b0;
`ifdef PROC_PERF_CNT_EN
            instret_q  <= '0;
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            regs_q     <= regs_d;
            halted_q   <= halted_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
`ifdef PROC_PERF_CNT_EN
            instret_q  <= instret_d;
            stall_q    <= stall_d;
`endif
        end
    end

endmodule
